// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver. It double-buffers a packed hex word and scans
// one digit per slot, with a one-cycle anode blanking gap, leading-zero suppression and selectable polarity.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

  // Hex to segment pattern, active-low form {a,b,c,d,e,f,g}.
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b1100000;
      4'hC:    pat = 7'b0110001;
      4'hD:    pat = 7'b1000010;
      4'hE:    pat = 7'b0110000;
      4'hF:    pat = 7'b0111000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  logic [4*DIGITS-1:0] pend_val_r, disp_val_r;
  logic [DIGITS-1:0]   pend_dp_r, disp_dp_r;
  logic [CW-1:0]       cnt_r;
  logic [IW-1:0]       idx_r;

  logic                tick_s, last_s, upper_nz_s, blank_s, dp_sel_s;
  logic [3:0]          nib_s;
  logic [DIGITS-1:0]   onehot_s, an_next_s;
  logic [6:0]          pat_s, seg_next_s;
  logic                dp_next_s;

  // Select the active digit's nibble/dp and work out whether it is a leading zero.
  always_comb begin
    tick_s     = (cnt_r == CNT_LAST);
    last_s     = (idx_r == IDX_LAST);
    nib_s      = 4'h0;
    dp_sel_s   = 1'b0;
    upper_nz_s = 1'b0;
    onehot_s   = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_r == IW'(i)) begin
        nib_s       = disp_val_r[4*i +: 4];
        dp_sel_s    = disp_dp_r[i];
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
      // A non-zero nibble at or above the active digit keeps it visible.
      if ((IW'(i) >= idx_r) && (disp_val_r[4*i +: 4] != 4'h0)) begin
        upper_nz_s = 1'b1;
      end else begin
        upper_nz_s = upper_nz_s;
      end
    end
    blank_s    = LZ_BLANK && (idx_r != {IW{1'b0}}) && !upper_nz_s;
    pat_s      = blank_s ? 7'b1111111 : decode_hex(nib_s);
    seg_next_s = SEG_ACTIVE_LOW ? pat_s : ~pat_s;
    dp_next_s  = SEG_ACTIVE_LOW ? ~dp_sel_s : dp_sel_s;
    an_next_s  = AN_ACTIVE_LOW ? ~onehot_s : onehot_s;
  end

  // Pending buffer: the last load before a swap wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_val_r <= {(4*DIGITS){1'b0}};
      pend_dp_r  <= {DIGITS{1'b0}};
    end else if (load) begin
      pend_val_r <= value;
      pend_dp_r  <= dp_in;
    end
  end

  // Slot counter, digit index, frame swap and registered display outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_val_r <= {(4*DIGITS){1'b0}};
      disp_dp_r  <= {DIGITS{1'b0}};
      cnt_r      <= {CW{1'b0}};
      idx_r      <= {IW{1'b0}};
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else if (tick_s) begin
      // Blanking cycle: anodes off while segments hold, so the next digit never ghosts.
      cnt_r      <= {CW{1'b0}};
      idx_r      <= last_s ? {IW{1'b0}} : idx_r + IW'(1);
      an         <= AN_OFF;
      frame_done <= last_s;
      if (last_s) begin
        disp_val_r <= pend_val_r;
        disp_dp_r  <= pend_dp_r;
      end
    end else begin
      cnt_r      <= cnt_r + CW'(1);
      an         <= an_next_s;
      seg        <= seg_next_s;
      dp         <= dp_next_s;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver: an active-low and an active-high instance share stimulus
// and are compared each cycle against a slot/frame arithmetic model.
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int S = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         load  = 1'b0;
  logic [15:0]  value = 16'h0;
  logic [3:0]   dp_in = 4'h0;

  logic [6:0] seg_l, seg_h;
  logic       dp_l, dp_h, fd_l, fd_h;
  logic [3:0] an_l, an_h;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) dut_l (
    .clock(clock), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg_l), .dp(dp_l), .an(an_l), .frame_done(fd_l));

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)) dut_h (
    .clock(clock), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h));

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Reference model state (expected outputs kept in active-low form)
  int          n;
  logic [15:0] m_pend_v, m_disp_v;
  logic [3:0]  m_pend_d, m_disp_d;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [3:0]  e_an;
  logic [6:0]  tbl [16];

  wire  [12:0] got_l = {seg_l, dp_l, an_l, fd_l};
  wire  [12:0] got_h = {seg_h, dp_h, an_h, fd_h};
  logic [12:0] exp_l, exp_h;
  always_comb begin
    exp_l = {e_seg, e_dp, e_an, e_fd};
    exp_h = {~e_seg, ~e_dp, ~e_an, e_fd};
  end

  task automatic model_reset();
    n = 0;
    m_pend_v = 16'h0; m_disp_v = 16'h0; m_pend_d = 4'h0; m_disp_d = 4'h0;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
  endtask

  // One clock edge worth of the display rules: slot position from the edge count.
  task automatic model_edge(input logic ld, input logic [15:0] v, input logic [3:0] d);
    int idx_b;
    bit tick, swap;
    idx_b = (n / S) % D;
    tick  = (n % S) == S - 1;
    swap  = tick && (idx_b == D - 1);
    if (tick) begin
      e_an = 4'hF;
      e_fd = swap;
    end else begin
      e_an  = ~(4'b0001 << idx_b);
      e_seg = (idx_b > 0 && (m_disp_v >> (4 * idx_b)) == 16'h0) ? 7'h7F : tbl[m_disp_v[4*idx_b +: 4]];
      e_dp  = ~m_disp_d[idx_b];
      e_fd  = 1'b0;
    end
    if (swap) begin
      m_disp_v = m_pend_v;
      m_disp_d = m_pend_d;
    end
    if (ld) begin
      m_pend_v = v;
      m_pend_d = d;
    end
    n++;
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
    load = ld; value = v; dp_in = d;
    @(posedge clock);
    model_edge(ld, v, d);
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks += 2;
    if (got_l !== 13'b1111111_1_1111_0) $display("FAIL reset_low: got %b expected %b", got_l, 13'b1111111_1_1111_0); else passed++;
    if (got_h !== 13'b0000000_0_0000_0) $display("FAIL reset_high: got %b expected %b", got_h, 13'b0000000_0_0000_0); else passed++;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 16'h0, 4'h0);
      if (k == 0) begin
        checks++;
        if (an_l !== 4'b1110 || seg_l !== 7'b0000001 || dp_l !== 1'b1)
          $display("FAIL first_edge: got an=%b seg=%b dp=%b expected an=1110 seg=0000001 dp=1", an_l, seg_l, dp_l);
        else passed++;
      end
      checks += 2;
      if (got_l !== exp_l) $display("FAIL reset_scan_low: cyc %0d got %b expected %b", k, got_l, exp_l); else passed++;
      if (got_h !== exp_h) $display("FAIL reset_scan_high: cyc %0d got %b expected %b", k, got_h, exp_h); else passed++;
    end
  endtask

  task automatic test_load_12af();
    bit swapped = 0;
    for (int k = 0; k < 5; k++) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h12AF, 4'b0100);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 16'h0, 4'h0);
      if (fd_l) swapped = 1;
      if (swapped && an_l == 4'b1011) begin
        checks++;
        if (seg_l !== 7'b0010010 || dp_l !== 1'b0)
          $display("FAIL digit2_12af: got seg=%b dp=%b expected seg=0010010 dp=0", seg_l, dp_l);
        else passed++;
      end
      checks += 2;
      if (got_l !== exp_l) $display("FAIL load_12af_low: cyc %0d got %b expected %b", k, got_l, exp_l); else passed++;
      if (got_h !== exp_h) $display("FAIL load_12af_high: cyc %0d got %b expected %b", k, got_h, exp_h); else passed++;
    end
  endtask

  task automatic test_lz();
    bit swapped = 0;
    step(1'b1, 16'h0030, 4'b1000);
    for (int k = 0; k < 36; k++) begin
      step(1'b0, 16'h0, 4'h0);
      if (fd_l) swapped = 1;
      if (swapped && an_l == 4'b0111) begin
        checks++;
        if (seg_l !== 7'b1111111 || dp_l !== 1'b0)
          $display("FAIL digit3_lz_dp: got seg=%b dp=%b expected seg=1111111 dp=0", seg_l, dp_l);
        else passed++;
      end
      checks += 2;
      if (got_l !== exp_l) $display("FAIL lz_low: cyc %0d got %b expected %b", k, got_l, exp_l); else passed++;
      if (got_h !== exp_h) $display("FAIL lz_high: cyc %0d got %b expected %b", k, got_h, exp_h); else passed++;
    end
  endtask

  task automatic test_swap_load();
    int last_fd = -1;
    int k = 0;
    while (n % (D * S) != 10 && k < 32) begin
      step(1'b0, 16'h0, 4'h0);
      k++;
    end
    step(1'b1, 16'h0456, 4'b0010);
    while (n % (D * S) != D * S - 1 && k < 64) begin
      step(1'b0, 16'h0, 4'h0);
      k++;
    end
    step(1'b1, 16'hBEEF, 4'b0001);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) step(1'b0, 16'h0, 4'h0);
      if (fd_l) begin
        if (last_fd >= 0) begin
          checks++;
          if (c - last_fd !== D * S) $display("FAIL frame_period: got %0d expected %0d", c - last_fd, D * S); else passed++;
        end
        last_fd = c;
      end
      checks += 2;
      if (got_l !== exp_l) $display("FAIL swap_load_low: cyc %0d got %b expected %b", c, got_l, exp_l); else passed++;
      if (got_h !== exp_h) $display("FAIL swap_load_high: cyc %0d got %b expected %b", c, got_h, exp_h); else passed++;
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic        ld;
    for (int k = 0; k < 300; k++) begin
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(ld, v, 4'($urandom));
      checks += 2;
      if (got_l !== exp_l) $display("FAIL random_low: cyc %0d got %b expected %b", k, got_l, exp_l); else passed++;
      if (got_h !== exp_h) $display("FAIL random_high: cyc %0d got %b expected %b", k, got_h, exp_h); else passed++;
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'h9876, 4'b1111);
    for (int k = 0; k < 21; k++) step(1'b0, 16'h0, 4'h0);
    #2 reset = 1'b1;
    #1;
    checks += 2;
    if (got_l !== 13'b1111111_1_1111_0) $display("FAIL async_reset_low: got %b expected %b", got_l, 13'b1111111_1_1111_0); else passed++;
    if (got_h !== 13'b0000000_0_0000_0) $display("FAIL async_reset_high: got %b expected %b", got_h, 13'b0000000_0_0000_0); else passed++;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 16'h0, 4'h0);
      if (k == 0) begin
        checks++;
        if (an_l !== 4'b1110 || seg_l !== 7'b0000001)
          $display("FAIL restart_digit0: got an=%b seg=%b expected an=1110 seg=0000001", an_l, seg_l);
        else passed++;
      end
      checks += 2;
      if (got_l !== exp_l) $display("FAIL post_reset_low: cyc %0d got %b expected %b", k, got_l, exp_l); else passed++;
      if (got_h !== exp_h) $display("FAIL post_reset_high: cyc %0d got %b expected %b", k, got_h, exp_h); else passed++;
    end
  endtask

  initial begin
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    model_reset();
    test_reset();
    test_load_12af();
    test_lz();
    test_swap_load();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
